bs_pp_gen: RTL and testbench
============================

# bs_pp_gen

Binary-serial partial-product generator and sequencer that drives the per-PE accumulator. It serializes an 8-bit signed weight MSB-first, emits one sign-extended partial product per cycle on `prod`, and issues the `clr` / `en` / `mac_done` control sequence the accumulator consumes. It sits upstream of each PE accumulator in the binary-serial systolic array.

## Interface
- `IBITW`, default 8: activation width, signed.
- `WBITW`, default 8: weight width, signed; one shift cycle per bit.
- `WIDTH`, default 24: `prod` width; must equal the accumulator width.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `stall`  in  1  freezes the sequence in place.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  operand pair accepted when `in_valid` and `in_ready` are both high.
- `ifm`  in  IBITW  signed activation.
- `wght`  in  WBITW  signed weight.
- `clr`  out  1  accumulator clear.
- `en`  out  1  accumulator enable.
- `mac_done`  out  1  accumulator adds `sum_i` this cycle instead of a partial product.
- `prod`  out  WIDTH  signed partial product.
- `out_valid`  out  1  one-cycle pulse; the accumulator output holds the finished sum this cycle.

## Operation
- States: IDLE, CLR, SHIFT, DONE. Encoding is an enum in the shared package.
- IDLE:
  - `in_ready`=1 while `stall`=0.
  - On handshake: latch `ifm` and `wght`, load bit counter `k`=WBITW-1, go to CLR.
- CLR: `clr`=1, then go to SHIFT.
- SHIFT: `en`=1 and `prod` = `wbit[k]` ? `sext(ifm)` : 0.
  - When `k`=WBITW-1 (the sign bit), `prod` = `-sext(ifm)`.
  - Decrement `k` each cycle. When `k`=0, go to DONE.
- DONE: `en`=1, `mac_done`=1, `prod`=0.
  - `in_ready`=1 while `stall`=0.
  - Handshake this cycle: go to CLR (back-to-back operation). Otherwise go to IDLE.
- `out_valid` is registered and pulses the cycle after DONE.
- Arithmetic: `sext(ifm)` to WIDTH, then negate in WIDTH bits. `-(-128)` = +128 does not overflow at WIDTH=24.
- Combined with the accumulator's `sum = prod + 2*sum`, the finished value is `ifm*wght + sum_i`.
- `stall`=1:
  - State, counter and latched operands are frozen.
  - `clr`, `en`, `mac_done`, `in_ready` are forced to 0. `prod` holds its value.
  - A `stall` asserted during DONE delays `out_valid`.
- Outputs are decoded from registered state and operands only. The only combinational input-to-output path is `stall` → `in_ready`/`en`/`clr`/`mac_done`.
- Reset, at any time including mid-sequence:
  - Go to IDLE, `k`=0, latched operands 0.
  - All outputs 0 except `in_ready`, which is 1 once `rst_n` is high and `stall`=0.

## Timing
- Handshake in cycle T: `clr` at T+1, SHIFT T+2..T+1+WBITW, DONE T+2+WBITW, `out_valid` T+3+WBITW.
- Latency 11 cycles at WBITW=8. Back-to-back throughput is one MAC per WBITW+2 cycles.
- In back-to-back operation, `out_valid` coincides with the next CLR cycle. The sum is still valid in that cycle and is cleared at its end.
- `in_valid` during CLR or SHIFT is ignored; `in_ready`=0 in those states.

## Configuration
- Macro `BS_EARLY_TERM_EN`.
- Defined:
  - At handshake, effective width `E` = WBITW − (count of leading bits equal to the MSB) + 1, minimum 1.
  - `k` loads `E-1`, and bit `E-1` is treated as the sign bit.
  - Weights 0 and −1 take one SHIFT cycle; weight 5 takes four. Latency becomes E+3.
- Undefined: SHIFT always lasts WBITW cycles, and no leading-sign logic is instantiated.

## Structure
- Shared package `bs_pkg`: state enum `bs_state_t`, plus default IBITW / WBITW / WIDTH localparams.
- Sub-module `lead_sign_cnt`: combinational leading-redundant-sign-bit counter over WBITW bits. Instantiated only under `BS_EARLY_TERM_EN`.

## Test plan
- `ifm`=3, `wght`=5 → `prod` sequence 0,0,0,0,0,3,0,3; accumulator model with `sum_i`=100 gives 115 at the `out_valid` cycle, T+11.
- `ifm`=−7, `wght`=−128 → first `prod`=+7, rest 0; result 896.
- `ifm`=−128, `wght`=−1 → `prod` 128 then seven × −128; result 128. With `BS_EARLY_TERM_EN`: single `prod`=128, `out_valid` at T+4.
- Back-to-back: `in_valid` held high with pairs (2,3) then (4,−1) → `out_valid` at T+11 and T+21; results 6 and −4.
- `stall` high for 3 cycles during SHIFT at `k`=4 → `en`=0 for those 3 cycles, `prod` held, `out_valid` at T+14, result unchanged.
- `rst_n` low mid-SHIFT → all outputs 0 immediately; after release, IDLE with `in_ready`=1 and a new MAC completes correctly.

Source files
------------

// File: rtl/bs_pkg.sv
// Shared types and default widths for the binary-serial partial-product generator.
package bs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR,
        ST_SHIFT,
        ST_DONE
    } bs_state_t;

    localparam int unsigned BS_IBITW = 8;
    localparam int unsigned BS_WBITW = 8;
    localparam int unsigned BS_WIDTH = 24;

endpackage

// File: rtl/lead_sign_cnt.sv
// Counts the leading bits of din that equal its MSB, the MSB included (result 1..WBITW).
module lead_sign_cnt #(
    parameter int unsigned WBITW = 8,
    parameter int unsigned CW    = $clog2(WBITW + 1)
) (
    input  logic [WBITW-1:0] din,
    output logic [CW-1:0]    cnt
);

    logic run;

    always_comb begin
        cnt = CW'(1);
        run = 1'b1;
        for (int unsigned j = 1; j < WBITW; j++) begin
            if (run && (din[WBITW-1-j] == din[WBITW-1])) begin
                cnt = cnt + CW'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bs_pp_gen.sv
// Serialises a signed weight MSB-first into sign-extended partial products and sequences
// the accumulator (clr / en / mac_done). Define BS_EARLY_TERM_EN to skip redundant sign bits.
module bs_pp_gen
    import bs_pkg::*;
#(
    parameter int unsigned IBITW = BS_IBITW,
    parameter int unsigned WBITW = BS_WBITW,
    parameter int unsigned WIDTH = BS_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IBITW-1:0] ifm,
    input  logic signed [WBITW-1:0] wght,
    output logic                    clr,
    output logic                    en,
    output logic                    mac_done,
    output logic signed [WIDTH-1:0] prod,
    output logic                    out_valid
);

    localparam int unsigned KW = (WBITW > 1) ? $clog2(WBITW) : 1;

    bs_state_t               state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic signed [IBITW-1:0] ifm_q, ifm_d;
    logic [WBITW-1:0]        wght_q, wght_d;
    logic                    out_valid_q, out_valid_d;
    logic [KW-1:0]           k_load;
    logic [KW-1:0]           sign_k;
    logic                    hs;
    logic signed [WIDTH-1:0] ifm_ext;

`ifdef BS_EARLY_TERM_EN
    localparam int unsigned CW = $clog2(WBITW + 1);

    logic [CW-1:0] lsc_cnt;
    logic [CW-1:0] wbitw_c;
    logic [KW-1:0] top_q, top_d;

    lead_sign_cnt #(.WBITW(WBITW), .CW(CW)) u_lead_sign_cnt (
        .din (wght),
        .cnt (lsc_cnt)
    );

    // E-1 = WBITW - cnt; cnt never exceeds WBITW, so this is always a valid bit index.
    assign wbitw_c = CW'(WBITW);
    assign k_load  = KW'(wbitw_c - lsc_cnt);
    assign sign_k  = top_q;

    always_comb begin
        top_d = top_q;
        if (hs) begin
            top_d = k_load;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            top_q <= '0;
        end else begin
            top_q <= top_d;
        end
    end
`else
    assign k_load = KW'(WBITW - 1);
    assign sign_k = k_load;
`endif

    assign in_ready = rst_n && !stall && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign hs       = in_valid && in_ready;
    assign clr      = !stall && (state_q == ST_CLR);
    assign en       = !stall && ((state_q == ST_SHIFT) || (state_q == ST_DONE));
    assign mac_done = !stall && (state_q == ST_DONE);
    assign out_valid = out_valid_q;
    assign ifm_ext  = {{(WIDTH-IBITW){ifm_q[IBITW-1]}}, ifm_q};

    // Decoded purely from registered state, so it holds by itself while stalled.
    always_comb begin
        prod = '0;
        if ((state_q == ST_SHIFT) && wght_q[k_q]) begin
            prod = (k_q == sign_k) ? -ifm_ext : ifm_ext;
        end
    end

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        ifm_d       = ifm_q;
        wght_d      = wght_q;
        out_valid_d = (state_q == ST_DONE) && !stall;
        if (!stall) begin
            case (state_q)
                ST_IDLE: begin
                    if (hs) begin
                        state_d = ST_CLR;
                    end
                end
                ST_CLR: state_d = ST_SHIFT;
                ST_SHIFT: begin
                    if (k_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q - KW'(1);
                    end
                end
                ST_DONE: state_d = hs ? ST_CLR : ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            if (hs) begin
                ifm_d  = ifm;
                wght_d = wght;
                k_d    = k_load;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            ifm_q       <= '0;
            wght_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            ifm_q       <= ifm_d;
            wght_q      <= wght_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_bs_pp_gen.sv
// Directed bench for bs_pp_gen with a behavioural accumulator (sum = prod + 2*sum).
module tb_bs_pp_gen;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              stall = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] ifm = '0;
    logic signed [7:0] wght = '0;
    logic              clr;
    logic              en;
    logic              mac_done;
    logic signed [23:0] prod;
    logic              out_valid;

    logic signed [23:0] acc = '0;
    logic signed [23:0] sum_i = '0;
    int ntest = 0;
    int nfail = 0;

    int p_a[8];
    int p_b[8];
    int p_c[8];
    int p_d[8];
    int p_e[8];
    int p_st[8];
    int p_z[8];
    int n_a, n_b, n_c, n_d, n_e, n_st;

    bs_pp_gen #(.IBITW(8), .WBITW(8), .WIDTH(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .stall     (stall),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ifm       (ifm),
        .wght      (wght),
        .clr       (clr),
        .en        (en),
        .mac_done  (mac_done),
        .prod      (prod),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= mac_done ? (acc + sum_i) : (prod + (acc <<< 1));
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        ntest++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic shifts(input int pe[8], input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk); #1;
            chk("shift_en", en, 1);
            chk("shift_prod", prod, pe[i]);
        end
    endtask

    task automatic done_and_result(input int res);
        @(negedge clk); #1;
        chk("done_mac_done", mac_done, 1);
        chk("done_en", en, 1);
        chk("done_prod", prod, 0);
        chk("done_out_valid", out_valid, 0);
        @(negedge clk); #1;
        chk("out_valid", out_valid, 1);
        chk("result", acc, res);
        @(negedge clk); #1;
        chk("out_valid_pulse", out_valid, 0);
    endtask

    task automatic mac(input int a, input int w, input int si, input int pe[8], input int n, input int res);
        @(negedge clk);
        in_valid = 1'b1; ifm = 8'(a); wght = 8'(w); sum_i = 24'(si);
        #1 chk("hs_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("clr", clr, 1);
        chk("clr_en", en, 0);
        chk("clr_ready", in_ready, 0);
        shifts(pe, n);
        done_and_result(res);
    endtask

    initial begin
        p_z = '{0, 0, 0, 0, 0, 0, 0, 0};
`ifdef BS_EARLY_TERM_EN
        p_a = '{0, 3, 0, 3, 0, 0, 0, 0};              n_a = 4;
        p_b = '{7, 0, 0, 0, 0, 0, 0, 0};              n_b = 8;
        p_c = '{128, 0, 0, 0, 0, 0, 0, 0};            n_c = 1;
        p_d = '{0, 2, 2, 0, 0, 0, 0, 0};              n_d = 3;
        p_e = '{-4, 0, 0, 0, 0, 0, 0, 0};             n_e = 1;
        p_st = '{0, -7, 0, 0, 0, 0, 0, 0};            n_st = 6;
`else
        p_a = '{0, 0, 0, 0, 0, 3, 0, 3};              n_a = 8;
        p_b = '{7, 0, 0, 0, 0, 0, 0, 0};              n_b = 8;
        p_c = '{128, -128, -128, -128, -128, -128, -128, -128}; n_c = 8;
        p_d = '{0, 0, 0, 0, 0, 0, 2, 2};              n_d = 8;
        p_e = '{-4, 4, 4, 4, 4, 4, 4, 4};             n_e = 8;
        p_st = '{0, 0, 0, -7, 0, 0, 0, 0};            n_st = 8;
`endif

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_clr", clr, 0);
        chk("rst_en", en, 0);
        chk("rst_prod", prod, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("post_rst_ready", in_ready, 1);

        // stall in IDLE blocks the handshake
        @(negedge clk);
        stall = 1'b1; in_valid = 1'b1; ifm = 8'sd9; wght = 8'sd9;
        #1 chk("idle_stall_ready", in_ready, 0);
        @(negedge clk);
        stall = 1'b0; in_valid = 1'b0;
        #1 chk("idle_stall_no_clr", clr, 0);
        chk("idle_ready_again", in_ready, 1);

        mac(3, 5, 100, p_a, n_a, 115);
        mac(-7, -128, 0, p_b, n_b, 896);
        mac(-128, -1, 0, p_c, n_c, 128);

        // back-to-back: second pair accepted in the first pair's DONE cycle
        @(negedge clk);
        in_valid = 1'b1; ifm = 8'sd2; wght = 8'sd3; sum_i = '0;
        #1 chk("b2b_ready", in_ready, 1);
        @(negedge clk);
        ifm = 8'sd4; wght = -8'sd1;
        #1 chk("b2b_clr1", clr, 1);
        chk("b2b_clr_ready", in_ready, 0);
        shifts(p_d, n_d);
        @(negedge clk); #1;
        chk("b2b_done1", mac_done, 1);
        chk("b2b_done1_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("b2b_clr2", clr, 1);
        chk("b2b_out_valid1", out_valid, 1);
        chk("b2b_result1", acc, 6);
        shifts(p_e, n_e);
        done_and_result(-4);

        // stall for three cycles while k = 4
        @(negedge clk);
        in_valid = 1'b1; ifm = -8'sd7; wght = 8'sd16; sum_i = 24'sd10;
        #1 chk("st_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("st_clr", clr, 1);
        shifts(p_st, n_st - 5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            #1 chk("st_en_low", en, 0);
            chk("st_prod_held", prod, -7);
            chk("st_ready_low", in_ready, 0);
        end
        @(negedge clk);
        stall = 1'b0;
        #1 chk("st_resume_en", en, 1);
        chk("st_resume_prod", prod, -7);
        shifts(p_z, 4);
        done_and_result(-102);

        // reset in the middle of a sequence
        @(negedge clk);
        in_valid = 1'b1; ifm = -8'sd128; wght = -8'sd1; sum_i = '0;
        #1 chk("mr_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("mr_clr", clr, 1);
        shifts(p_c, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("mr_clr0", clr, 0);
        chk("mr_en0", en, 0);
        chk("mr_mac_done0", mac_done, 0);
        chk("mr_prod0", prod, 0);
        chk("mr_out_valid0", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("mr_ready_after", in_ready, 1);
        chk("mr_en_after", en, 0);
        mac(3, 5, 7, p_a, n_a, 22);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule
